apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.
REQ-004 pclk  input  1  single clock; all state updates on the rising edge.
REQ-005 prst  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  transfer request present.
REQ-007 cmd_ready  output  1  block can accept a request.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data of the completed transfer.
REQ-013 rsp_err  output  1  completion carried an error (slave error or timeout).
REQ-014 rsp_timeout  output  1  completion was a timeout abort.
REQ-015 psel, penable, pwrite  output  1 each  APB control.
REQ-016 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address and write data.
REQ-017 prdata  input  DATA_W; pready, pslverr  input  1 each  APB slave response.

Function
REQ-018 The block SHALL implement the FSM states IDLE, SETUP and ACCESS, with all APB outputs registered.
REQ-019 cmd_ready SHALL equal (state == IDLE) and SHALL be 0 while prst is low.
REQ-020 In IDLE, when cmd_valid and cmd_ready are both high, the block SHALL latch addr/wdata/write into paddr/pwdata/pwrite and enter SETUP on the next edge.
REQ-021 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then enter ACCESS.
REQ-022 ACCESS SHALL drive psel=1, penable=1, with paddr/pwdata/pwrite held stable.
REQ-023 pready and pslverr SHALL be sampled only in ACCESS; pslverr is ignored while pready=0.
REQ-024 On a rising edge in ACCESS with pready=1: the next cycle SHALL show rsp_valid=1, rsp_err=pslverr, rsp_timeout=0, rsp_rdata=prdata for reads or 0 for writes, psel=0, penable=0, state IDLE.
REQ-025 Minimum latency SHALL be 3 cycles from acceptance to rsp_valid: SETUP, ACCESS, then response.
REQ-026 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-027 When TIMEOUT>0 and the counter reaches TIMEOUT with pready still 0, the block SHALL return to IDLE next cycle with psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-028 pready=1 on the same edge the counter would reach TIMEOUT SHALL count as a normal completion, not a timeout.
REQ-029 rsp_valid SHALL be high for exactly one cycle per accepted command; there is no response backpressure.
REQ-030 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next completion.
REQ-031 A new command SHALL be acceptable in the same cycle rsp_valid is high, giving back-to-back transfers with one idle (psel=0) cycle between them.
REQ-032 paddr/pwdata/pwrite SHALL keep their last values in IDLE; cmd_* inputs are ignored outside IDLE.

Reset
REQ-033 Asserting prst low SHALL immediately force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, and clear the wait counter.
REQ-034 A transfer in flight when reset asserts SHALL be dropped with no rsp_valid; the first accept is possible on the first rising edge after prst goes high.

Verification
REQ-035 Zero-wait write: cmd write addr=0x10 data=0xA5A5A5A5, slave pready=1 in ACCESS -> SETUP one cycle, ACCESS one cycle, rsp_valid=1 with rsp_err=0 on the 3rd cycle after accept.
REQ-036 Read with 2 wait states: addr=0x10, pready low 2 ACCESS cycles, then high with prdata=0xA5A5A5A5 -> ACCESS lasts 3 cycles, rsp_rdata=0xA5A5A5A5, rsp_err=0.
REQ-037 Slave error: addr=0x100, pready=1, pslverr=1 -> rsp_valid=1, rsp_err=1, rsp_timeout=0.
REQ-038 Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1; with TIMEOUT=0 psel stays high indefinitely.
REQ-039 Back-to-back: cmd_valid held high for two commands -> second accepted in the rsp_valid cycle, exactly one psel=0 cycle between transfers.
REQ-040 Reset mid-ACCESS: prst low during ACCESS -> psel/penable drop 0 asynchronously, no rsp_valid, cmd_ready=1 on the first edge after release.

Source files
------------

// File: rtl/apb_master.sv
// APB master: turns single-request command handshakes into APB SETUP/ACCESS
// transfers and returns a one-cycle completion pulse with optional timeout abort.
module apb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Counter only has to reach TIMEOUT-1: the abort is taken on the edge it would hit TIMEOUT.
  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          TO_EN    = (TIMEOUT != 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt, wait_d;
  logic                psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic                rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                timeout_hit;

  assign cmd_ready   = (state_q == IDLE) && prst;
  assign timeout_hit = TO_EN && (wait_cnt == CNT_W'(CNT_LAST));

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_cnt;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end

      ACCESS: begin
        if (pready) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite ? '0 : prdata;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (TO_EN) begin
          wait_d = wait_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q     <= IDLE;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt    <= wait_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule
